gshare_predictor: RTL and testbench

Gshare direction predictor plus direct-mapped branch target buffer for the five-stage pipeline. Consumes the fetch-stage global history (`ghr_F`) and fetch PC, and returns a same-cycle taken/target prediction to fetch. Accepts resolved-branch updates from execute, trains the pattern history table (PHT) and BTB, flags mispredictions with a redirect PC, and keeps saturating performance counters.

---
 rtl/bp_pkg.sv | 12 +
 rtl/branch_target_buffer.sv | 35 +++
 rtl/gshare_predictor.sv | 61 ++++++
 tb/tb_gshare_predictor.sv | 134 +++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared encodings, widths and saturating helpers for the branch predictor
package bp_pkg;
  typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} ctr_t;
  localparam ctr_t PHT_RESET = WNT;
  localparam int PERF_W = 16;
  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction
  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction
endpackage

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped target cache indexed and tagged by word-aligned PC
module branch_target_buffer #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-3:0] rd_pc,
  output logic            rd_hit,
  output logic [PC_W-1:0] rd_target,
  input  logic            wr_en,
  input  logic [PC_W-3:0] wr_pc,
  input  logic [PC_W-1:0] wr_target
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = PC_W - 2 - IDX_W;
  logic [N-1:0]     valid;
  logic [TAG_W-1:0] tags    [N];
  logic [PC_W-1:0]  targets [N];
  logic [IDX_W-1:0] rd_idx, wr_idx;
  assign rd_idx    = rd_pc[IDX_W-1:0];
  assign wr_idx    = wr_pc[IDX_W-1:0];
  assign rd_hit    = valid[rd_idx] && tags[rd_idx] == rd_pc[PC_W-3:IDX_W];
  assign rd_target = targets[rd_idx];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      valid   <= '0;
      tags    <= '{default: '0};
      targets <= '{default: '0};
    end else if (wr_en) begin
      valid[wr_idx]   <= 1'b1;
      tags[wr_idx]    <= wr_pc[PC_W-3:IDX_W];
      targets[wr_idx] <= wr_target;
    end
endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare direction PHT plus BTB, mispredict detection and perf counters
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int GHR_W     = 5,
  parameter int PC_W      = 32,
  parameter int BTB_IDX_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc_F,
  input  logic [GHR_W-1:0]  ghr_F,
  output logic              predict_taken_F,
  output logic [PC_W-1:0]   predict_target_F,
  input  logic              update_en,
  input  logic [PC_W-1:0]   update_pc,
  input  logic [GHR_W-1:0]  update_ghr,
  input  logic              update_taken,
  input  logic [PC_W-1:0]   update_target,
  input  logic              pred_taken_E,
  input  logic [PC_W-1:0]   pred_target_E,
  output logic              mispredict_E,
  output logic [PC_W-1:0]   redirect_pc_E,
  output logic [PERF_W-1:0] branch_count,
  output logic [PERF_W-1:0] mispredict_count
);
  logic [1:0]       pht [1 << GHR_W];
  logic [GHR_W-1:0] rd_idx, wr_idx;
  logic             btb_hit;
  logic [PC_W-1:0]  btb_target;
  assign rd_idx = pc_F[GHR_W+1:2] ^ ghr_F;
  assign wr_idx = update_pc[GHR_W+1:2] ^ update_ghr;
  branch_target_buffer #(.PC_W(PC_W), .IDX_W(BTB_IDX_W)) u_btb (
    .clock     (clock),
    .reset     (reset),
    .rd_pc     (pc_F[PC_W-1:2]),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (update_en && update_taken),
    .wr_pc     (update_pc[PC_W-1:2]),
    .wr_target (update_target)
  );
  assign predict_taken_F  = pht[rd_idx][1] && btb_hit;
  assign predict_target_F = predict_taken_F ? btb_target : pc_F + PC_W'(4);
  assign mispredict_E     = update_en && (update_taken != pred_taken_E ||
                            (update_taken && pred_taken_E && update_target != pred_target_E));
  assign redirect_pc_E    = update_taken ? update_target : update_pc + PC_W'(4);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pht              <= '{default: 2'(PHT_RESET)};
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (update_en)
        pht[wr_idx] <= update_taken ? sat_inc2(pht[wr_idx]) : sat_dec2(pht[wr_idx]);
      if (update_en && branch_count != '1)
        branch_count <= branch_count + 1'b1;
      if (mispredict_E && mispredict_count != '1)
        mispredict_count <= mispredict_count + 1'b1;
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed vectors with hand-computed predictions, redirects and counts
module tb_gshare_predictor;
  logic        clock, reset;
  logic [31:0] pc_F;
  logic [4:0]  ghr_F;
  logic        predict_taken_F;
  logic [31:0] predict_target_F;
  logic        update_en;
  logic [31:0] update_pc;
  logic [4:0]  update_ghr;
  logic        update_taken;
  logic [31:0] update_target;
  logic        pred_taken_E;
  logic [31:0] pred_target_E;
  logic        mispredict_E;
  logic [31:0] redirect_pc_E;
  logic [15:0] branch_count, mispredict_count;
  int total = 0;
  int bad = 0;
  gshare_predictor dut (
    .clock            (clock),
    .reset            (reset),
    .pc_F             (pc_F),
    .ghr_F            (ghr_F),
    .predict_taken_F  (predict_taken_F),
    .predict_target_F (predict_target_F),
    .update_en        (update_en),
    .update_pc        (update_pc),
    .update_ghr       (update_ghr),
    .update_taken     (update_taken),
    .update_target    (update_target),
    .pred_taken_E     (pred_taken_E),
    .pred_target_E    (pred_target_E),
    .mispredict_E     (mispredict_E),
    .redirect_pc_E    (redirect_pc_E),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic [4:0] ghr,
                      input logic exp_t, input logic [31:0] exp_tgt);
    pc_F  = pc;
    ghr_F = ghr;
    #1;
    chk({tag, "_taken"}, 32'(predict_taken_F), 32'(exp_t));
    chk({tag, "_target"}, predict_target_F, exp_tgt);
  endtask
  task automatic upd(input string tag, input logic [31:0] pc, input logic [4:0] ghr,
                     input logic t, input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                     input logic exp_mp, input logic [31:0] exp_rd);
    @(negedge clock);
    update_en     = 1'b1;
    update_pc     = pc;
    update_ghr    = ghr;
    update_taken  = t;
    update_target = tgt;
    pred_taken_E  = pt;
    pred_target_E = ptgt;
    #1;
    chk({tag, "_mp"}, 32'(mispredict_E), 32'(exp_mp));
    chk({tag, "_redirect"}, redirect_pc_E, exp_rd);
    @(negedge clock);
    update_en = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    pc_F = '0; ghr_F = '0;
    update_en = 1'b0; update_pc = '0; update_ghr = '0;
    update_taken = 1'b0; update_target = '0;
    pred_taken_E = 1'b0; pred_target_E = '0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    look("rst", 32'h100, 5'd0, 1'b0, 32'h104);
    chk("rst_bcnt", 32'(branch_count), 32'd0);
    chk("rst_mcnt", 32'(mispredict_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    // same-cycle lookup during the first training update sees the untrained entry
    @(negedge clock);
    update_en = 1'b1; update_pc = 32'h100; update_ghr = 5'd0;
    update_taken = 1'b1; update_target = 32'h200;
    pred_taken_E = 1'b0; pred_target_E = 32'h0;
    look("same_cyc", 32'h100, 5'd0, 1'b0, 32'h104);
    chk("upd1_mp", 32'(mispredict_E), 32'd1);
    @(negedge clock);
    update_en = 1'b0;
    upd("upd2", 32'h100, 5'd0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
    look("trained", 32'h100, 5'd0, 1'b1, 32'h200);
    chk("cnt2_b", 32'(branch_count), 32'd2);
    chk("cnt2_m", 32'(mispredict_count), 32'd1);
    for (int i = 0; i < 5; i++)
      upd("nt", 32'h100, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104);
    look("sat0", 32'h100, 5'd0, 1'b0, 32'h104);
    look("alias", 32'h100, 5'h1F, 1'b0, 32'h104);
    // pc 0x104 trains PHT index 1; lookup 0x100^ghr1 reuses it against the untouched BTB slot 0
    upd("t104a", 32'h104, 5'd0, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 32'h300);
    upd("t104b", 32'h104, 5'd0, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 32'h300);
    look("btb_kept", 32'h100, 5'd1, 1'b1, 32'h200);
    chk("cnt9_b", 32'(branch_count), 32'd9);
    upd("mp_tgt", 32'h100, 5'd2, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 32'h300);
    chk("mp_tgt_cnt", 32'(mispredict_count), 32'd2);
    upd("mp_nt", 32'h100, 5'd2, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h104);
    chk("mp_nt_cnt", 32'(mispredict_count), 32'd3);
    chk("cnt11_b", 32'(branch_count), 32'd11);
    update_pc = 32'hFFFF_FFFC; update_taken = 1'b0; pred_taken_E = 1'b1;
    #1;
    chk("idle_redirect", redirect_pc_E, 32'h0);
    chk("idle_mp", 32'(mispredict_E), 32'd0);
    look("pc_wrap", 32'hFFFF_FFFC, 5'd0, 1'b0, 32'h0);
    look("pre_rst", 32'h100, 5'd1, 1'b1, 32'h300);
    update_en = 1'b1; update_pc = 32'h100; update_ghr = 5'd1;
    update_taken = 1'b1; update_target = 32'h400; pred_taken_E = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_b", 32'(branch_count), 32'd0);
    chk("mid_rst_m", 32'(mispredict_count), 32'd0);
    look("mid_rst", 32'h100, 5'd1, 1'b0, 32'h104);
    @(negedge clock);
    update_en = 1'b0;
    reset = 1'b1;
    look("post_rst", 32'h100, 5'd1, 1'b0, 32'h104);
    chk("post_rst_b", 32'(branch_count), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
